// File: rtl/pc_stack.sv
// Program counter with an integrated return-address stack (RAS).
// One action per clock edge, chosen by a fixed priority:
//   reset > stall > write > offset > call > ret > inc.
// The ovf/udf error flags are sticky. They can be cleared by clr_err, even while stalled.
// The address and data buses are tristated whenever their read enables are low.
module pc_stack #(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 8,
    parameter int INC_STEP  = 2,
    parameter int RET_STEP  = 4,
    parameter int RESET_VEC = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           din,
    input  logic                       write,
    input  logic                       offset,
    input  logic                       inc,
    input  logic                       call,
    input  logic                       ret,
    input  logic                       stall,
    input  logic                       clr_err,
    input  logic                       read,
    input  logic                       readplusone,
    input  logic                       readret,
    input  logic                       readtop,
    output logic [WIDTH-1:0]           abus_out,
    output logic [WIDTH-1:0]           dbus_out,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       full,
    output logic                       empty,
    output logic                       ovf,
    output logic                       udf
);

    localparam int DW = $clog2(DEPTH+1);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] pc_q;
    logic [DW-1:0]    depth_q;
    logic             ovf_q;
    logic             udf_q;
    logic [WIDTH-1:0] ras [DEPTH];

    logic [WIDTH-1:0] ret_addr;
    logic [DW-1:0]    top_idx;
    logic [WIDTH-1:0] top_val;
    logic             do_call;
    logic             do_ret;
    logic             do_push;

    // Decode which action wins this cycle, and derive the stack pointers.
    always_comb begin
        do_call  = 1'b0;
        do_ret   = 1'b0;
        ret_addr = pc_q + WIDTH'(RET_STEP);
        top_idx  = depth_q - DW'(1);
        top_val  = ras[top_idx[AW-1:0]];
        if (!reset && !stall && !write && !offset) begin
            do_call = call;
            do_ret  = ret && !call;
        end
        do_push = do_call && !full;
    end

    // Update the PC, the occupancy count and the sticky flags.
    // A flag set is ordered after clr_err, so a new error wins over a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= WIDTH'(RESET_VEC);
            depth_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            if (clr_err) begin
                ovf_q <= 1'b0;
                udf_q <= 1'b0;
            end
            if (!stall) begin
                if (write) begin
                    pc_q <= din;
                end else if (offset) begin
                    pc_q <= pc_q + din;
                end else if (do_call) begin
                    pc_q <= din;
                    if (full) ovf_q <= 1'b1;
                    else      depth_q <= depth_q + DW'(1);
                end else if (do_ret) begin
                    if (empty) begin
                        udf_q <= 1'b1;
                    end else begin
                        pc_q    <= top_val;
                        depth_q <= top_idx;
                    end
                end else if (inc) begin
                    pc_q <= pc_q + WIDTH'(INC_STEP);
                end
            end
        end
    end

    // RAS storage: no reset, because entries above the current depth are never read.
    always_ff @(posedge clk) begin
        if (do_push) ras[depth_q[AW-1:0]] <= ret_addr;
    end

    assign depth = depth_q;
    assign full  = (depth_q == DW'(DEPTH));
    assign empty = (depth_q == '0);
    assign ovf   = ovf_q;
    assign udf   = udf_q;

    // Bus drivers. When a bus is not enabled it is released to high-Z.
    assign abus_out = read        ? pc_q :
                      readplusone ? pc_q + WIDTH'(1) : 'z;
    assign dbus_out = readtop     ? (empty ? '0 : top_val) :
                      readret     ? ret_addr : 'z;

endmodule

// File: tb/tb_pc_stack.sv
module tb_pc_stack;

  localparam int W = 16;
  localparam int D = 8;

  localparam logic [7:0] OP_W  = 8'h01;
  localparam logic [7:0] OP_O  = 8'h02;
  localparam logic [7:0] OP_I  = 8'h04;
  localparam logic [7:0] OP_C  = 8'h08;
  localparam logic [7:0] OP_R  = 8'h10;
  localparam logic [7:0] OP_S  = 8'h20;
  localparam logic [7:0] OP_CE = 8'h40;
  localparam logic [7:0] OP_RS = 8'h80;

  logic clk = 1'b0;
  logic reset;
  logic [W-1:0] din;
  logic write, offset, inc, call, ret, stall, clr_err;
  logic read, readplusone, readret, readtop;
  logic [W-1:0] abus_out, dbus_out;
  logic [3:0] depth;
  logic full, empty, ovf, udf;

  int checks = 0;
  int failures = 0;

  // Each entry packs the expected {ras_top, pc, depth, full, empty, ovf, udf}.
  logic [39:0] exp_q[$];

  // Reference model state.
  logic [W-1:0] m_pc;
  logic [W-1:0] m_ras[$];
  logic m_ovf, m_udf;

  pc_stack #(.WIDTH(W), .DEPTH(D), .INC_STEP(2), .RET_STEP(4), .RESET_VEC(0)) dut (
    .clk(clk), .reset(reset), .din(din), .write(write), .offset(offset), .inc(inc),
    .call(call), .ret(ret), .stall(stall), .clr_err(clr_err), .read(read),
    .readplusone(readplusone), .readret(readret), .readtop(readtop),
    .abus_out(abus_out), .dbus_out(dbus_out), .depth(depth), .full(full),
    .empty(empty), .ovf(ovf), .udf(udf)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [39:0] model_pack();
    logic [W-1:0] top;
    logic [3:0] d;
    d = 4'(m_ras.size());
    top = (m_ras.size() == 0) ? '0 : m_ras[m_ras.size()-1];
    return {top, m_pc, d, (d == 4'(D)), (d == 4'd0), m_ovf, m_udf};
  endfunction

  // Advance the model for one cycle of the given inputs.
  task automatic model_step(input logic [W-1:0] d, input logic [7:0] op);
    logic [W-1:0] ra;
    if (op & OP_RS) begin
      m_pc = '0;
      m_ras.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      if (op & OP_CE) begin
        m_ovf = 1'b0;
        m_udf = 1'b0;
      end
      if (!(op & OP_S)) begin
        if (op & OP_W) m_pc = d;
        else if (op & OP_O) m_pc = m_pc + d;
        else if (op & OP_C) begin
          ra = m_pc + 16'd4;
          if (m_ras.size() == D) m_ovf = 1'b1;
          else m_ras.push_back(ra);
          m_pc = d;
        end else if (op & OP_R) begin
          if (m_ras.size() == 0) m_udf = 1'b1;
          else m_pc = m_ras.pop_back();
        end else if (op & OP_I) m_pc = m_pc + 16'd2;
      end
    end
  endtask

  // Driver: apply one cycle of inputs, push the expectation, then pop and compare after the edge.
  task automatic cycle(input logic [W-1:0] d, input logic [7:0] op);
    logic [39:0] e;
    din = d;
    write = op[0]; offset = op[1]; inc = op[2]; call = op[3];
    ret = op[4]; stall = op[5]; clr_err = op[6]; reset = op[7];
    model_step(d, op);
    exp_q.push_back(model_pack());
    @(posedge clk);
    #1;
    {write, offset, inc, call, ret, stall, clr_err, reset} = '0;
    e = exp_q.pop_front();
    check("pc", 32'(abus_out), 32'(e[23:8]));
    check("depth", 32'(depth), 32'(e[7:4]));
    check("full", 32'(full), 32'(e[3]));
    check("empty", 32'(empty), 32'(e[2]));
    check("ovf", 32'(ovf), 32'(e[1]));
    check("udf", 32'(udf), 32'(e[0]));
    check("ras_top", 32'(dbus_out), 32'(e[39:24]));
  endtask

  initial begin
    logic [7:0] op;
    logic [W-1:0] d;
    din = '0;
    {write, offset, inc, call, ret, stall, clr_err} = '0;
    reset = 1'b1;
    read = 1'b1; readplusone = 1'b0; readret = 1'b0; readtop = 1'b1;
    m_pc = '0; m_ovf = 1'b0; m_udf = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state.
    cycle('0, OP_RS);
    check("reset_pc", 32'(abus_out), 32'h0000);
    check("reset_empty", 32'(empty), 32'd1);

    // Three increments, then the address-bus enables.
    cycle('0, OP_I);
    check("inc1", 32'(abus_out), 32'h0002);
    cycle('0, OP_I);
    cycle('0, OP_I);
    check("inc3", 32'(abus_out), 32'h0006);
    read = 1'b0;
    #1;
    check("abus_released", 32'(abus_out === 16'h0006), 32'd0);
    readplusone = 1'b1;
    #1;
    check("readplusone", 32'(abus_out), 32'h0007);
    read = 1'b1;
    #1;
    check("read_wins", 32'(abus_out), 32'h0006);
    readplusone = 1'b0;

    // Relative branch backwards, and wrap on increment.
    cycle(16'h0100, OP_W);
    cycle(16'hFFF0, OP_O);
    check("offset_neg", 32'(abus_out), 32'h00F0);
    cycle(16'hFFFE, OP_W);
    cycle('0, OP_I);
    check("inc_wrap", 32'(abus_out), 32'h0000);

    // Single call/return, with both data-bus sources.
    cycle(16'h0010, OP_W);
    cycle(16'h0200, OP_C);
    check("call_pc", 32'(abus_out), 32'h0200);
    check("call_top", 32'(dbus_out), 32'h0014);
    readtop = 1'b0; readret = 1'b1;
    #1;
    check("readret", 32'(dbus_out), 32'h0204);
    readret = 1'b0;
    #1;
    check("dbus_released", 32'(dbus_out === 16'h0204), 32'd0);
    readtop = 1'b1;
    cycle('0, OP_R);
    check("ret_pc", 32'(abus_out), 32'h0014);
    check("ret_empty", 32'(empty), 32'd1);

    // Fill the stack, overflow it, drain it in LIFO order, then underflow it.
    for (int k = 0; k <= D; k++) cycle(16'h1000 + 16'(k * 16), OP_C);
    check("ovf_pc", 32'(abus_out), 32'(16'h1000 + 16'(D * 16)));
    check("ovf_full", 32'(full), 32'd1);
    check("ovf_flag", 32'(ovf), 32'd1);
    for (int k = 0; k < D; k++) cycle('0, OP_R);
    check("lifo_last", 32'(abus_out), 32'h0018);
    cycle('0, OP_R);
    check("udf_flag", 32'(udf), 32'd1);
    check("udf_pc_hold", 32'(abus_out), 32'h0018);

    // A stall freezes state, but clr_err still clears the flags.
    cycle(16'h4444, OP_S | OP_W | OP_C);
    check("stall_pc", 32'(abus_out), 32'h0018);
    cycle(16'h4444, OP_S | OP_CE);
    check("clr_under_stall", 32'({ovf, udf}), 32'd0);

    // Priority: write wins over offset and inc.
    cycle(16'h1234, OP_W | OP_O | OP_I);
    check("prio_write", 32'(abus_out), 32'h1234);

    // A new error wins over clr_err in the same cycle.
    cycle('0, OP_R | OP_CE);
    check("set_beats_clr", 32'(udf), 32'd1);
    cycle('0, OP_CE);

    // Reset right after a call.
    cycle(16'h0300, OP_C);
    check("pre_reset_depth", 32'(depth), 32'd1);
    cycle(16'h5555, OP_RS | OP_W | OP_C);
    check("reset_mid", 32'({abus_out, depth, ovf, udf}), 32'h0);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      op = 8'($urandom_range(0, 127));
      if ($urandom_range(0, 3) != 0) op = op & ~OP_S;
      if ($urandom_range(0, 3) != 0) op = op & ~(OP_W | OP_O);
      if ($urandom_range(0, 63) == 0) op = op | OP_RS;
      d = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(0, 65535)) : 16'($urandom_range(0, 15));
      cycle(d, op);
    end

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
